// File: rtl/vga_pkg.sv
// Shared VGA timing types, controller state encoding and the fixed mode table
// consumed by vga_mode_ctrl and vga_mode_rom.
package vga_pkg;

  localparam int VGA_MAX_H_WIDTH = 12;
  localparam int VGA_MAX_V_WIDTH = 11;

  typedef struct packed {
    logic [VGA_MAX_H_WIDTH-1:0] hd;
    logic [VGA_MAX_H_WIDTH-1:0] hf;
    logic [VGA_MAX_H_WIDTH-1:0] hr;
    logic [VGA_MAX_H_WIDTH-1:0] hb;
    logic [VGA_MAX_V_WIDTH-1:0] vd;
    logic [VGA_MAX_V_WIDTH-1:0] vf;
    logic [VGA_MAX_V_WIDTH-1:0] vr;
    logic [VGA_MAX_V_WIDTH-1:0] vb;
  } vga_timing_t;

  typedef enum logic [2:0] {
    INIT    = 3'd0,
    IDLE    = 3'd1,
    WAIT_VS = 3'd2,
    LOAD    = 3'd3,
    SETTLE  = 3'd4
  } vga_ctrl_state_t;

  // Display / front porch / sync / back porch, horizontal then vertical.
  localparam vga_timing_t VGA_MODE_TABLE [4] = '{
    '{12'd640,  12'd16, 12'd96,  12'd48,  11'd480, 11'd10, 11'd2, 11'd33},
    '{12'd800,  12'd40, 12'd128, 12'd88,  11'd600, 11'd1,  11'd4, 11'd23},
    '{12'd1024, 12'd24, 12'd136, 12'd160, 11'd768, 11'd3,  11'd6, 11'd29},
    '{12'd320,  12'd8,  12'd48,  12'd24,  11'd240, 11'd5,  11'd1, 11'd16}
  };

endpackage

// File: rtl/vga_mode_rom.sv
// Combinational mode-table lookup: mode index in, full timing set out.
module vga_mode_rom
  import vga_pkg::*;
(
  input  logic [1:0]  mode,
  output vga_timing_t timing
);

  // Table select
  always_comb begin
    timing = VGA_MODE_TABLE[0];
    case (mode)
      2'd0:    timing = VGA_MODE_TABLE[0];
      2'd1:    timing = VGA_MODE_TABLE[1];
      2'd2:    timing = VGA_MODE_TABLE[2];
      2'd3:    timing = VGA_MODE_TABLE[3];
      default: timing = VGA_MODE_TABLE[0];
    endcase
  end

endmodule

// File: rtl/vga_mode_ctrl.sv
// VGA mode-change controller: loads timing sets on a VS boundary and blanks for a few frames.
// Define VGA_MODE_CTRL_TIMEOUT_EN to add a 20-bit watchdog on the VS waits.
module vga_mode_ctrl
  import vga_pkg::*;
#(
  parameter int NUM_MODES     = 4,
  parameter int SETTLE_FRAMES = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       req_valid_i,
  input  logic [1:0]                 req_mode_i,
  output logic                       req_ready_o,
  input  logic                       vga_vs_i,
  output logic [VGA_MAX_H_WIDTH-1:0] hd_o,
  output logic [VGA_MAX_H_WIDTH-1:0] hf_o,
  output logic [VGA_MAX_H_WIDTH-1:0] hr_o,
  output logic [VGA_MAX_H_WIDTH-1:0] hb_o,
  output logic [VGA_MAX_V_WIDTH-1:0] vd_o,
  output logic [VGA_MAX_V_WIDTH-1:0] vf_o,
  output logic [VGA_MAX_V_WIDTH-1:0] vr_o,
  output logic [VGA_MAX_V_WIDTH-1:0] vb_o,
  output logic                       we_o,
  output logic                       blank_o,
  output logic [1:0]                 cur_mode_o,
  output logic                       err_o
);

  vga_ctrl_state_t state;
  vga_timing_t     timing_q;
  vga_timing_t     rom_timing;
  logic            vs_q;
  logic [1:0]      pend_mode;
  logic [3:0]      settle_cnt;
  logic [3:0]      settle_next;
  logic            settle_done;
  logic            vs_start;
  logic            mode_ok;
  logic            wait_go;
`ifdef VGA_MODE_CTRL_TIMEOUT_EN
  logic [19:0]     to_cnt;
  logic            to_hit;
`endif

  vga_mode_rom u_rom (
    .mode   (pend_mode),
    .timing (rom_timing)
  );

  assign hd_o = timing_q.hd;
  assign hf_o = timing_q.hf;
  assign hr_o = timing_q.hr;
  assign hb_o = timing_q.hb;
  assign vd_o = timing_q.vd;
  assign vf_o = timing_q.vf;
  assign vr_o = timing_q.vr;
  assign vb_o = timing_q.vb;

  // Sync-edge detection, request validation and settle bookkeeping
  always_comb begin
    vs_start    = vs_q & ~vga_vs_i;
    mode_ok     = (int'(req_mode_i) < NUM_MODES);
    settle_next = (settle_cnt == 4'hF) ? settle_cnt : settle_cnt + 4'd1;
    settle_done = (int'(settle_next) >= SETTLE_FRAMES);
`ifdef VGA_MODE_CTRL_TIMEOUT_EN
    to_hit      = (to_cnt == 20'hF_FFFF);
    wait_go     = vs_start | to_hit;
`else
    wait_go     = vs_start;
`endif
  end

  // Mode-change state machine with registered outputs
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= INIT;
      vs_q        <= 1'b1;
      pend_mode   <= 2'd0;
      settle_cnt  <= 4'd0;
      timing_q    <= VGA_MODE_TABLE[0];
      cur_mode_o  <= 2'd0;
      we_o        <= 1'b0;
      blank_o     <= 1'b1;
      req_ready_o <= 1'b0;
      err_o       <= 1'b0;
`ifdef VGA_MODE_CTRL_TIMEOUT_EN
      to_cnt      <= 20'd0;
`endif
    end else begin
      vs_q  <= vga_vs_i;
      we_o  <= 1'b0;
      err_o <= 1'b0;
      case (state)
        INIT: begin
          state      <= LOAD;
          we_o       <= 1'b1;
          timing_q   <= rom_timing;
          cur_mode_o <= pend_mode;
        end
        IDLE: begin
          if (req_valid_i && req_ready_o) begin
            if (!mode_ok) begin
              err_o <= 1'b1;
            end else if (req_mode_i != cur_mode_o) begin
              pend_mode   <= req_mode_i;
              req_ready_o <= 1'b0;
              blank_o     <= 1'b1;
              state       <= WAIT_VS;
`ifdef VGA_MODE_CTRL_TIMEOUT_EN
              to_cnt      <= 20'd0;
`endif
            end
          end
        end
        WAIT_VS: begin
`ifdef VGA_MODE_CTRL_TIMEOUT_EN
          to_cnt <= to_cnt + 20'd1;
`endif
          if (wait_go) begin
            state      <= LOAD;
            we_o       <= 1'b1;
            timing_q   <= rom_timing;
            cur_mode_o <= pend_mode;
`ifdef VGA_MODE_CTRL_TIMEOUT_EN
            err_o      <= ~vs_start;
`endif
          end
        end
        LOAD: begin
          state      <= SETTLE;
          settle_cnt <= 4'd0;
`ifdef VGA_MODE_CTRL_TIMEOUT_EN
          to_cnt     <= 20'd0;
`endif
        end
        SETTLE: begin
`ifdef VGA_MODE_CTRL_TIMEOUT_EN
          to_cnt <= to_cnt + 20'd1;
`endif
          if (vs_start) begin
            settle_cnt <= settle_next;
            if (settle_done) begin
              state       <= IDLE;
              blank_o     <= 1'b0;
              req_ready_o <= 1'b1;
            end
`ifdef VGA_MODE_CTRL_TIMEOUT_EN
          end else if (to_hit) begin
            state       <= IDLE;
            blank_o     <= 1'b0;
            req_ready_o <= 1'b1;
            err_o       <= 1'b1;
`endif
          end
        end
        default: begin
          state       <= INIT;
          blank_o     <= 1'b1;
          req_ready_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vga_mode_ctrl.sv
// Scoreboard bench for vga_mode_ctrl: two instances (4 modes/2 settle frames and
// 3 modes/3 settle frames) share directed then random stimulus.
module tb_vga_mode_ctrl;
  import vga_pkg::*;

  localparam int ND = 2;

  typedef struct {
    int cyc;
    bit is_err;
    int mode;
  } ev_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1;
  logic       vs  = 1'b1;
  logic       rv  = 1'b0;
  logic [1:0] rm  = 2'd0;

  logic                       rdy   [ND];
  logic                       we    [ND];
  logic                       blank [ND];
  logic                       err   [ND];
  logic [1:0]                 cur   [ND];
  logic [VGA_MAX_H_WIDTH-1:0] hd [ND], hf [ND], hr [ND], hb [ND];
  logic [VGA_MAX_V_WIDTH-1:0] vd [ND], vf [ND], vr [ND], vb [ND];

  vga_mode_ctrl #(.NUM_MODES(4), .SETTLE_FRAMES(2)) u_dut0 (
    .clk_i(clk), .rst_i(rst), .req_valid_i(rv), .req_mode_i(rm), .req_ready_o(rdy[0]),
    .vga_vs_i(vs), .hd_o(hd[0]), .hf_o(hf[0]), .hr_o(hr[0]), .hb_o(hb[0]),
    .vd_o(vd[0]), .vf_o(vf[0]), .vr_o(vr[0]), .vb_o(vb[0]),
    .we_o(we[0]), .blank_o(blank[0]), .cur_mode_o(cur[0]), .err_o(err[0])
  );

  vga_mode_ctrl #(.NUM_MODES(3), .SETTLE_FRAMES(3)) u_dut1 (
    .clk_i(clk), .rst_i(rst), .req_valid_i(rv), .req_mode_i(rm), .req_ready_o(rdy[1]),
    .vga_vs_i(vs), .hd_o(hd[1]), .hf_o(hf[1]), .hr_o(hr[1]), .hb_o(hb[1]),
    .vd_o(vd[1]), .vf_o(vf[1]), .vr_o(vr[1]), .vb_o(vb[1]),
    .we_o(we[1]), .blank_o(blank[1]), .cur_mode_o(cur[1]), .err_o(err[1])
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  bit checking = 1'b0;

  // Reference model: high-level view of each controller
  bit m_init [ND], m_ready [ND], m_wait [ND], m_load [ND], m_blank [ND], m_vsq [ND];
  int m_settle [ND], m_pend [ND], m_cur [ND];
  bit exp_ready [ND], exp_blank [ND];
  int exp_cur [ND];
  ev_t q0[$];
  ev_t q1[$];

  function automatic int nm(int d);
    return (d == 0) ? 4 : 3;
  endfunction

  function automatic int sf(int d);
    return (d == 0) ? 2 : 3;
  endfunction

  function automatic logic [91:0] ref_timing(int m);
    case (m)
      0:       return {12'd640, 12'd16, 12'd96, 12'd48, 11'd480, 11'd10, 11'd2, 11'd33};
      1:       return {12'd800, 12'd40, 12'd128, 12'd88, 11'd600, 11'd1, 11'd4, 11'd23};
      2:       return {12'd1024, 12'd24, 12'd136, 12'd160, 11'd768, 11'd3, 11'd6, 11'd29};
      3:       return {12'd320, 12'd8, 12'd48, 12'd24, 11'd240, 11'd5, 11'd1, 11'd16};
      default: return 92'd0;
    endcase
  endfunction

  function automatic void push(int d, bit is_err, int mode);
    ev_t e;
    e.cyc = cyc + 1;
    e.is_err = is_err;
    e.mode = mode;
    if (d == 0) q0.push_back(e);
    else q1.push_back(e);
  endfunction

  function automatic int qsize(int d);
    if (d == 0) return q0.size();
    else return q1.size();
  endfunction

  function automatic ev_t qfront(int d);
    if (d == 0) return q0[0];
    else return q1[0];
  endfunction

  function automatic ev_t qpop(int d);
    if (d == 0) return q0.pop_front();
    else return q1.pop_front();
  endfunction

  function automatic void model_reset(int d);
    m_init[d] = 1'b1; m_ready[d] = 1'b0; m_wait[d] = 1'b0; m_load[d] = 1'b0;
    m_blank[d] = 1'b1; m_vsq[d] = 1'b1; m_settle[d] = 0; m_pend[d] = 0; m_cur[d] = 0;
  endfunction

  function automatic void model_step(int d, bit r, bit v, bit val, int md);
    bit vs_start;
    if (r) begin
      model_reset(d);
      return;
    end
    vs_start = m_vsq[d] && !v;
    m_vsq[d] = v;
    if (m_init[d]) begin
      m_init[d] = 1'b0; m_load[d] = 1'b1; m_cur[d] = 0;
      push(d, 1'b0, 0);
    end else if (m_load[d]) begin
      m_load[d] = 1'b0; m_settle[d] = sf(d);
    end else if (m_wait[d]) begin
      if (vs_start) begin
        m_wait[d] = 1'b0; m_load[d] = 1'b1; m_cur[d] = m_pend[d];
        push(d, 1'b0, m_pend[d]);
      end
    end else if (m_settle[d] > 0) begin
      if (vs_start) begin
        m_settle[d] = m_settle[d] - 1;
        if (m_settle[d] == 0) begin
          m_ready[d] = 1'b1; m_blank[d] = 1'b0;
        end
      end
    end else if (val && m_ready[d]) begin
      if (md >= nm(d)) push(d, 1'b1, md);
      else if (md != m_cur[d]) begin
        m_pend[d] = md; m_wait[d] = 1'b1; m_ready[d] = 1'b0; m_blank[d] = 1'b1;
      end
    end
  endfunction

  function automatic void chk(string name, logic [127:0] act, logic [127:0] exp);
    n_cmp = n_cmp + 1;
    if (act !== exp) begin
      n_bad = n_bad + 1;
      $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  task automatic tick(input bit r, input bit v, input bit val, input logic [1:0] md);
    @(posedge clk);
    cyc = cyc + 1;
    for (int d = 0; d < ND; d++) begin
      exp_ready[d] = m_ready[d];
      exp_blank[d] = m_blank[d];
      exp_cur[d]   = m_cur[d];
    end
    checking = 1'b1;
    #1;
    rst = r; vs = v; rv = val; rm = md;
    for (int d = 0; d < ND; d++) model_step(d, r, v, val, int'(md));
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      repeat (8) tick(1'b0, 1'b1, 1'b0, 2'd0);
      repeat (2) tick(1'b0, 1'b0, 1'b0, 2'd0);
    end
  endtask

  // Monitor: levels every cycle, strobes popped from the scoreboard
  always @(negedge clk) begin
    if (checking) begin
      for (int d = 0; d < ND; d++) begin
        ev_t e;
        chk($sformatf("dut%0d_ready", d), rdy[d], exp_ready[d]);
        chk($sformatf("dut%0d_blank", d), blank[d], exp_blank[d]);
        chk($sformatf("dut%0d_cur_mode", d), cur[d], exp_cur[d][1:0]);
        chk($sformatf("dut%0d_timing", d),
            {hd[d], hf[d], hr[d], hb[d], vd[d], vf[d], vr[d], vb[d]}, ref_timing(exp_cur[d]));
        if (we[d] || err[d]) begin
          if (qsize(d) == 0) begin
            chk($sformatf("dut%0d_unexpected_we_err", d), {we[d], err[d]}, 2'b00);
          end else begin
            e = qpop(d);
            chk($sformatf("dut%0d_event_cycle", d), cyc, e.cyc);
            chk($sformatf("dut%0d_event_we_err", d), {we[d], err[d]}, {~e.is_err, e.is_err});
          end
        end else if (qsize(d) > 0 && qfront(d).cyc <= cyc) begin
          e = qpop(d);
          chk($sformatf("dut%0d_missing_we_err", d), {we[d], err[d]}, {~e.is_err, e.is_err});
        end
      end
    end
  end

  initial begin
    int per, low, pos;
    for (int d = 0; d < ND; d++) model_reset(d);

    repeat (3) tick(1'b1, 1'b1, 1'b0, 2'd0);
    frames(5);
    tick(1'b0, 1'b1, 1'b1, 2'd3);              // mode 3: load on dut0, error on dut1
    frames(5);
    tick(1'b0, 1'b1, 1'b1, 2'd1);
    frames(5);
    tick(1'b0, 1'b1, 1'b1, 2'd1);              // same mode again: no-op
    repeat (3) tick(1'b0, 1'b1, 1'b0, 2'd0);
    tick(1'b0, 1'b0, 1'b1, 2'd2);              // VS start coincides with acceptance
    repeat (3) tick(1'b0, 1'b0, 1'b0, 2'd0);
    repeat (5) tick(1'b0, 1'b1, 1'b0, 2'd0);
    frames(1);
    repeat (4) tick(1'b0, 1'b1, 1'b0, 2'd0);   // settling after the mode 2 load
    repeat (2) tick(1'b1, 1'b1, 1'b0, 2'd0);
    frames(5);

    per = 24; low = 2; pos = 0;
    for (int i = 0; i < 3000; i++) begin
      bit v;
      bit r;
      v = (pos < low) ? 1'b0 : 1'b1;
      pos = pos + 1;
      if (pos >= per) begin
        pos = 0;
        per = $urandom_range(12, 40);
        low = $urandom_range(1, 3);
      end
      r = ($urandom_range(0, 599) == 0);
      tick(r, v, ($urandom_range(0, 3) == 0), 2'($urandom_range(0, 3)));
    end

    repeat (3) tick(1'b0, 1'b1, 1'b0, 2'd0);
    @(negedge clk);
    #1;
    for (int d = 0; d < ND; d++) chk($sformatf("dut%0d_scoreboard_drained", d), qsize(d), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/vga_mode_ctrl.md
VGA_MODE_CTRL -- requirements
Module: vga_mode_ctrl

Interface
REQ-001 SHALL have parameter NUM_MODES, default 4, meaning the number of valid mode-table entries (1..4).
REQ-002 SHALL have parameter SETTLE_FRAMES, default 2, meaning frames blanked after a mode load (1..15).
REQ-003 SHALL have port clk_i, input, 1, the single clock.
REQ-004 SHALL have port rst_i, input, 1; reset is synchronous and active-high.
REQ-005 SHALL have port req_valid_i, input, 1, mode-change request valid.
REQ-006 SHALL have port req_mode_i, input, 2, requested mode index.
REQ-007 SHALL have port req_ready_o, output, 1, request accepted when req_valid_i and req_ready_o are both high.
REQ-008 SHALL have port vga_vs_i, input, 1, active-low vertical sync from the timing generator.
REQ-009 SHALL have ports hd_o, hf_o, hr_o, hb_o, outputs, VGA_MAX_H_WIDTH each, horizontal timings.
REQ-010 SHALL have ports vd_o, vf_o, vr_o, vb_o, outputs, VGA_MAX_V_WIDTH each, vertical timings.
REQ-011 SHALL have port we_o, output, 1, one-cycle timing-load strobe to the timing generator.
REQ-012 SHALL have port blank_o, output, 1, force-black request to the pixel path.
REQ-013 SHALL have port cur_mode_o, output, 2, index of the last loaded mode.
REQ-014 SHALL have port err_o, output, 1, one-cycle error pulse.

Function
REQ-015 SHALL implement FSM states INIT, IDLE, WAIT_VS, LOAD, SETTLE.
REQ-016 SHALL drive req_ready_o high only in IDLE.
REQ-017 SHALL detect a VS start as vs_q==1 && vga_vs_i==0, where vs_q is vga_vs_i registered once.
REQ-018 SHALL go from INIT to LOAD with mode 0 on the first cycle after reset deasserts.
REQ-019 SHALL, on acceptance with req_mode_i < NUM_MODES and req_mode_i != cur_mode_o, latch the mode and enter WAIT_VS the next cycle.
REQ-020 SHALL, on acceptance with req_mode_i >= NUM_MODES, pulse err_o for one cycle, stay in IDLE and leave all outputs unchanged.
REQ-021 SHALL treat acceptance with req_mode_i == cur_mode_o as a no-op: stay in IDLE, no we_o, no err_o.
REQ-022 SHALL ignore a VS start that occurs in the acceptance cycle; only VS starts seen while in WAIT_VS count.
REQ-023 SHALL enter LOAD on the cycle after the VS start is detected in WAIT_VS.
REQ-024 SHALL, in LOAD, drive we_o=1 for exactly one cycle, with the table values for the latched mode on the timing outputs and cur_mode_o updated in that same cycle.
REQ-025 SHALL hold the timing outputs stable at all times other than the LOAD cycle.
REQ-026 SHALL go from LOAD to SETTLE, holding blank_o=1 in WAIT_VS, LOAD and SETTLE.
REQ-027 SHALL stay in SETTLE until SETTLE_FRAMES VS starts have been counted, then go to IDLE with blank_o=0 on the next cycle.
REQ-028 SHALL use a SETTLE frame counter 4 bits wide that saturates and clears on entry to SETTLE.

Reset
REQ-029 SHALL, while rst_i is high, set state=INIT, we_o=0, blank_o=1, req_ready_o=0, err_o=0, cur_mode_o=0, vs_q=1, and the timing outputs to the mode-0 table values.
REQ-030 SHALL, when reset is asserted mid-operation in any state, abandon the pending request and redo the INIT mode-0 load.

Configuration
REQ-031 SHALL, with VGA_MODE_CTRL_TIMEOUT_EN defined, run a 20-bit cycle counter in WAIT_VS and SETTLE.
REQ-032 SHALL, with VGA_MODE_CTRL_TIMEOUT_EN defined, on counter overflow before the awaited VS start, pulse err_o and advance as if the VS start had occurred (WAIT_VS->LOAD, SETTLE->IDLE).
REQ-033 SHALL, without VGA_MODE_CTRL_TIMEOUT_EN, wait indefinitely and contain no timeout logic.

Structure
REQ-034 SHALL take struct type vga_timing_t (hd,hf,hr,hb,vd,vf,vr,vb) and constant VGA_MODE_TABLE[4] from vga_pkg, where VGA_MAX_H_WIDTH/VGA_MAX_V_WIDTH are also defined.
REQ-035 SHALL use these VGA_MODE_TABLE entries:
  - mode 0: 640/16/96/48, 480/10/2/33
  - mode 1: 800/40/128/88, 600/1/4/23
  - mode 2: 1024/24/136/160, 768/3/6/29
  - mode 3: 320/8/48/24, 240/5/1/16
REQ-036 SHALL implement the table lookup as one combinational sub-module, vga_mode_rom (mode index in, vga_timing_t out).

Verification
REQ-037 SHALL cover: reset release -> we_o pulses 1 cycle later with hd_o=640, vd_o=480, blank_o=1 until 2 VS starts have occurred.
REQ-038 SHALL cover: request mode 1 in IDLE -> ready drops, we_o pulses the cycle after the next VS start with hd_o=800, vb_o=23, cur_mode_o=1.
REQ-039 SHALL cover: NUM_MODES=3, request mode 3 -> err_o pulses 1 cycle, hd_o stays 640, no we_o.
REQ-040 SHALL cover: VS start in the same cycle as acceptance -> no we_o until the following VS start.
REQ-041 SHALL cover: rst_i asserted in SETTLE after a mode 2 load -> outputs return to mode-0 values and the INIT load repeats.
REQ-042 SHALL cover: VGA_MODE_CTRL_TIMEOUT_EN defined, vga_vs_i held 1 -> err_o and we_o follow 2^20 cycles after acceptance.
